// File: rtl/fpu_issue_sched_if.sv
// Decode <-> issue/writeback scheduler bundle for the multi-cycle EXEC units.
// Decode presents an instruction via issue_valid; it is taken in the same cycle iff issue_ready.
interface fpu_issue_sched_if;
  logic       issue_valid;
  logic [1:0] issue_unit;
  logic [4:0] issue_dst;
  logic       issue_dfpr;
  logic       issue_dwe;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       src_a_fpr;
  logic       src_b_fpr;
  logic       src_a_use;
  logic       src_b_use;
  logic       issue_ready;
  logic       wb_valid;
  logic [1:0] wb_unit;
  logic [4:0] wb_dst;
  logic       wb_fpr;
  logic       busy;
  logic [5:0] dbg_state;

  // Handshake: accept = issue_valid & issue_ready, both in one cycle; issue_ready never
  // depends on issue_valid, and the issue_* fields need only be stable while issue_valid is high.
  modport master (
    output issue_valid, issue_unit, issue_dst, issue_dfpr, issue_dwe,
    output src_a, src_b, src_a_fpr, src_b_fpr, src_a_use, src_b_use,
    input  issue_ready, wb_valid, wb_unit, wb_dst, wb_fpr, busy, dbg_state
  );

  modport slave (
    input  issue_valid, issue_unit, issue_dst, issue_dfpr, issue_dwe,
    input  src_a, src_b, src_a_fpr, src_b_fpr, src_a_use, src_b_use,
    output issue_ready, wb_valid, wb_unit, wb_dst, wb_fpr, busy, dbg_state
  );
endinterface

// File: rtl/fpu_issue_sched.sv
// Issue/writeback scheduler: scoreboards 32 GPR + 32 FPR, tracks LW/FDIV/FSQRT latency and
// arbitrates the single register-file write port (LW > DIV > SQRT).
module fpu_issue_sched #(
  parameter int LAT_LW   = 1,
  parameter int LAT_DIV  = 3,
  parameter int LAT_SQRT = 3
) (
  input logic             CLK,
  input logic             RST,
  fpu_issue_sched_if.slave io
);

  localparam int NU      = 3;
  localparam int MAX_LAT = (LAT_LW > LAT_DIV) ? ((LAT_LW > LAT_SQRT) ? LAT_LW : LAT_SQRT)
                                              : ((LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT);
  localparam int CW      = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_RUN  = 2'd1,
    U_DONE = 2'd2
  } unit_state_e;

  // Index 0..2 holds units 1..3 (LW, DIV, SQRT); the counter holds cycles left before DONE.
  function automatic logic [CW-1:0] lat_m1(input int u);
    case (u)
      0:       return CW'(LAT_LW - 1);
      1:       return CW'(LAT_DIV - 1);
      default: return CW'(LAT_SQRT - 1);
    endcase
  endfunction

  unit_state_e     state_q [NU];
  unit_state_e     state_d [NU];
  logic [CW-1:0]   cnt_q   [NU];
  logic [CW-1:0]   cnt_d   [NU];
  logic [4:0]      dst_q   [NU];
  logic [4:0]      dst_d   [NU];
  logic [NU-1:0]   fpr_q, fpr_d;
  logic [NU-1:0]   we_q, we_d;
  logic [63:0]     pending_q, pending_d;

  logic [NU-1:0]   req;
  logic [NU-1:0]   grant;
  logic            wb_valid;
  logic [1:0]      wb_unit;
  logic [4:0]      wb_dst;
  logic            wb_fpr;
  logic [5:0]      a_idx, b_idx, d_idx;
  logic            raw, waw, unit_busy, port_conflict, ready, accept;
  logic            any_active;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int u = 0; u < NU; u++) begin
        state_q[u] <= U_IDLE;
        cnt_q[u]   <= '0;
        dst_q[u]   <= '0;
      end
      fpr_q     <= '0;
      we_q      <= '0;
      pending_q <= '0;
    end else begin
      for (int u = 0; u < NU; u++) begin
        state_q[u] <= state_d[u];
        cnt_q[u]   <= cnt_d[u];
        dst_q[u]   <= dst_d[u];
      end
      fpr_q     <= fpr_d;
      we_q      <= we_d;
      pending_q <= pending_d;
    end
  end

  // A finished op that writes nothing never needs the port, so it does not request it.
  always_comb begin
    req   = '0;
    grant = '0;
    for (int u = 0; u < NU; u++) begin
      req[u] = (state_q[u] == U_DONE) && we_q[u];
    end
    if (req[0])      grant[0] = 1'b1;
    else if (req[1]) grant[1] = 1'b1;
    else if (req[2]) grant[2] = 1'b1;
  end

  always_comb begin
    wb_valid = 1'b0;
    wb_unit  = 2'd0;
    wb_dst   = 5'd0;
    wb_fpr   = 1'b0;
    for (int u = 0; u < NU; u++) begin
      if (grant[u]) begin
        wb_valid = 1'b1;
        wb_unit  = 2'(u + 1);
        wb_dst   = dst_q[u];
        wb_fpr   = fpr_q[u];
      end
    end
  end

  assign a_idx = {io.src_a_fpr, io.src_a};
  assign b_idx = {io.src_b_fpr, io.src_b};
  assign d_idx = {io.issue_dfpr, io.issue_dst};

  always_comb begin
    unit_busy = 1'b0;
    case (io.issue_unit)
      2'd1:    unit_busy = (state_q[0] != U_IDLE);
      2'd2:    unit_busy = (state_q[1] != U_IDLE);
      2'd3:    unit_busy = (state_q[2] != U_IDLE);
      default: unit_busy = 1'b0;
    endcase
  end

  // No bypass: a pending bit blocks readers until the cycle after its write.
  assign raw           = (io.src_a_use & pending_q[a_idx]) | (io.src_b_use & pending_q[b_idx]);
  assign waw           = io.issue_dwe & pending_q[d_idx];
  assign port_conflict = (io.issue_unit == 2'd0) & io.issue_dwe & wb_valid;
  assign ready         = ~(raw | waw | unit_busy | port_conflict);
  assign accept        = io.issue_valid & ready;

  always_comb begin
    for (int u = 0; u < NU; u++) begin
      state_d[u] = state_q[u];
      cnt_d[u]   = cnt_q[u];
      dst_d[u]   = dst_q[u];
    end
    fpr_d = fpr_q;
    we_d  = we_q;
    for (int u = 0; u < NU; u++) begin
      case (state_q[u])
        U_IDLE: begin
          if (accept && (io.issue_unit == 2'(u + 1))) begin
            dst_d[u]   = io.issue_dst;
            fpr_d[u]   = io.issue_dfpr;
            we_d[u]    = io.issue_dwe;
            cnt_d[u]   = lat_m1(u);
            state_d[u] = (lat_m1(u) == '0) ? U_DONE : U_RUN;
          end
        end
        U_RUN: begin
          cnt_d[u] = cnt_q[u] - 1'b1;
          if (cnt_q[u] == CW'(1)) state_d[u] = U_DONE;
        end
        U_DONE: begin
          if (grant[u] || !we_q[u]) state_d[u] = U_IDLE;
        end
        default: state_d[u] = U_IDLE;
      endcase
    end
  end

  // Set and clear never hit the same bit in one cycle: the WAW stall forbids it.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[{wb_fpr, wb_dst}] = 1'b0;
    if (accept && (io.issue_unit != 2'd0) && io.issue_dwe && (d_idx != 6'd0)) begin
      pending_d[d_idx] = 1'b1;
    end
  end

  always_comb begin
    any_active = 1'b0;
    for (int u = 0; u < NU; u++) begin
      if (state_q[u] != U_IDLE) any_active = 1'b1;
    end
  end

  assign io.issue_ready = ready;
  assign io.wb_valid    = wb_valid;
  assign io.wb_unit     = wb_unit;
  assign io.wb_dst      = wb_dst;
  assign io.wb_fpr      = wb_fpr;
  assign io.busy        = any_active | (|pending_q);
  assign io.dbg_state   = {state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: directed scenarios plus random traffic against a timestamp-based
// model (each unit remembers the cycle its result becomes due; pending is a 64-bit set).
module tb_fpu_issue_sched;
  localparam int LAT_LW   = 1;
  localparam int LAT_DIV  = 3;
  localparam int LAT_SQRT = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  fpu_issue_sched_if ifc ();

  fpu_issue_sched #(
    .LAT_LW  (LAT_LW),
    .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .io (ifc)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];

  int        cyc;
  bit        m_act [1:3];
  int        m_due [1:3];
  bit [4:0]  m_dst [1:3];
  bit        m_fpr [1:3];
  int        lat_tab [1:3];
  bit [63:0] m_pend;

  logic       o_ready, o_wbv, o_fpr, o_busy;
  logic [1:0] o_unit;
  logic [4:0] o_dst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int u = 1; u <= 3; u++) begin
      m_act[u] = 1'b0;
      m_due[u] = 0;
    end
    m_pend = '0;
  endtask

  function automatic bit model_busy();
    bit b;
    b = (m_pend != '0);
    for (int u = 1; u <= 3; u++) if (m_act[u]) b = 1'b1;
    return b;
  endfunction

  // One clock cycle: drive, predict, sample at negedge, compare, then advance the model.
  task automatic step(input bit rst, input bit v, input bit [1:0] unit, input bit [4:0] dst,
                      input bit dfpr, input bit dwe, input bit [4:0] sa, input bit saf,
                      input bit sau, input bit [4:0] sb, input bit sbf, input bit sbu);
    int         win;
    bit         e_ready, e_busy, e_fpr;
    bit [4:0]   e_dst;
    logic [10:0] e;
    @(posedge CLK);
    #1;
    RST             = rst;
    ifc.issue_valid = v;
    ifc.issue_unit  = unit;
    ifc.issue_dst   = dst;
    ifc.issue_dfpr  = dfpr;
    ifc.issue_dwe   = dwe;
    ifc.src_a       = sa;
    ifc.src_a_fpr   = saf;
    ifc.src_a_use   = sau;
    ifc.src_b       = sb;
    ifc.src_b_fpr   = sbf;
    ifc.src_b_use   = sbu;

    win = 0;
    for (int u = 1; u <= 3; u++) if (win == 0 && m_act[u] && cyc >= m_due[u]) win = u;
    e_ready = 1'b1;
    if (sau && m_pend[{saf, sa}]) e_ready = 1'b0;
    if (sbu && m_pend[{sbf, sb}]) e_ready = 1'b0;
    if (dwe && m_pend[{dfpr, dst}]) e_ready = 1'b0;
    if (unit != 2'd0) begin
      if (m_act[unit]) e_ready = 1'b0;
    end
    if (unit == 2'd0 && dwe && win != 0) e_ready = 1'b0;
    e_busy = model_busy();
    e_fpr  = (win != 0) ? m_fpr[win] : 1'b0;
    e_dst  = (win != 0) ? m_dst[win] : 5'd0;
    exp_q.push_back({e_ready, (win != 0), 2'(win), e_fpr, e_dst, e_busy});

    @(negedge CLK);
    o_ready = ifc.issue_ready;
    o_wbv   = ifc.wb_valid;
    o_unit  = ifc.wb_unit;
    o_dst   = ifc.wb_dst;
    o_fpr   = ifc.wb_fpr;
    o_busy  = ifc.busy;
    e = exp_q.pop_front();
    chk("issue_ready", o_ready, e[10]);
    chk("wb_valid", o_wbv, e[9]);
    chk("wb_unit", o_unit, e[8:7]);
    chk("wb_fpr", o_fpr, e[6]);
    chk("wb_dst", o_dst, e[5:1]);
    chk("busy", o_busy, e[0]);

    if (rst) begin
      model_reset();
    end else begin
      if (win != 0) begin
        m_act[win] = 1'b0;
        m_pend[{m_fpr[win], m_dst[win]}] = 1'b0;
      end
      if (v && e_ready && unit != 2'd0) begin
        m_act[unit] = 1'b1;
        m_due[unit] = cyc + lat_tab[unit];
        m_dst[unit] = dst;
        m_fpr[unit] = dfpr;
        if (dwe && {dfpr, dst} != 6'd0) m_pend[{dfpr, dst}] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic issue(input bit [1:0] unit, input bit [4:0] dst, input bit dfpr, input bit dwe,
                       input bit [4:0] sa, input bit saf, input bit sau);
    step(1'b0, 1'b1, unit, dst, dfpr, dwe, sa, saf, sau, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (model_busy() && k < 30) begin
      idle();
      k++;
    end
    idle();
    chk("drain_busy", o_busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         r;
    bit         v;
    bit [1:0]   un;
    bit         we;
    lat_tab[1] = LAT_LW;
    lat_tab[2] = LAT_DIV;
    lat_tab[3] = LAT_SQRT;
    cyc = 0;
    model_reset();
    ifc.issue_valid = 1'b0;
    ifc.issue_unit  = 2'd0;
    ifc.issue_dst   = 5'd0;
    ifc.issue_dfpr  = 1'b0;
    ifc.issue_dwe   = 1'b0;
    ifc.src_a       = 5'd0;
    ifc.src_b       = 5'd0;
    ifc.src_a_fpr   = 1'b0;
    ifc.src_b_fpr   = 1'b0;
    ifc.src_a_use   = 1'b0;
    ifc.src_b_use   = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);

    // Reset state
    idle();
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_wb_valid", o_wbv, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_wb_unit", o_unit, 2'd0);
    chk("rst_wb_dst", o_dst, 5'd0);

    // LW r5 then dependent ADD
    issue(2'd1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("lw_accept", o_ready, 1'b1);
    issue(2'd0, 5'd6, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    chk("raw_stall", o_ready, 1'b0);
    chk("lw_wb_valid", o_wbv, 1'b1);
    chk("lw_wb_unit", o_unit, 2'd1);
    chk("lw_wb_dst", o_dst, 5'd5);
    chk("lw_wb_fpr", o_fpr, 1'b0);
    issue(2'd0, 5'd6, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    chk("raw_release", o_ready, 1'b1);
    drain();

    // DIV f3, SQRT f4 back to back
    issue(2'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(2'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("sqrt_accept", o_ready, 1'b1);
    idle();
    idle();
    chk("div_wb_unit", o_unit, 2'd2);
    chk("div_wb_dst", o_dst, 5'd3);
    chk("div_wb_fpr", o_fpr, 1'b1);
    idle();
    chk("sqrt_wb_unit", o_unit, 2'd3);
    chk("sqrt_wb_dst", o_dst, 5'd4);
    idle();
    chk("div_sqrt_idle", o_busy, 1'b0);

    // DIV f3 and LW f7 due together: LW wins
    issue(2'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();
    issue(2'd1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();
    chk("prio_lw_unit", o_unit, 2'd1);
    chk("prio_lw_dst", o_dst, 5'd7);
    idle();
    chk("prio_div_unit", o_unit, 2'd2);
    chk("prio_div_dst", o_dst, 5'd3);
    issue(2'd0, 5'd9, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1);
    chk("f3_clear", o_ready, 1'b1);
    drain();

    // Second DIV waits through the write cycle of the first
    issue(2'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(2'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("div2_c1", o_ready, 1'b0);
    issue(2'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(2'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("div2_c3", o_ready, 1'b0);
    issue(2'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("div2_c4", o_ready, 1'b1);
    drain();

    // ALU write collides with DIV writeback
    issue(2'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();
    idle();
    issue(2'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("port_stall", o_ready, 1'b0);
    issue(2'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("port_release", o_ready, 1'b1);
    drain();

    // WAW on f3
    issue(2'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(2'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("waw_c1", o_ready, 1'b0);
    issue(2'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(2'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(2'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("waw_c4", o_ready, 1'b1);
    drain();

    // LW r0 never marks r0 pending
    issue(2'd1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(2'd0, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("r0_no_stall", o_ready, 1'b1);
    drain();

    // Reset in the middle of a DIV
    issue(2'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    issue(2'd0, 5'd10, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    chk("rst_mid_wb", o_wbv, 1'b0);
    chk("rst_mid_busy", o_busy, 1'b0);
    chk("rst_mid_ready", o_ready, 1'b1);
    drain();

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      v  = !r && ($urandom_range(0, 9) < 7);
      un = 2'($urandom_range(0, 3));
      we = (un != 2'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      step(r, v, un, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), we,
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
